dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Single-port data-memory arbiter between the pipeline MEM stage and a debug/loader port. It sits between the MEM stage and the `dataMemory` instance, passing CPU accesses through with zero added latency and granting idle cycles to the debug port. It enforces bounded debug wait time and provides a halt handshake that gives the debug port exclusive ownership of memory.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_WAIT`, 4, maximum consecutive cycles a pending debug request may lose to the CPU; range 1–15

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset
- `cpuReq`  in  1  MEM stage performs a load or store this cycle
- `cpuWe`  in  1  MEM stage access is a store
- `cpuAddr`  in  ADDR_W  MEM stage address (ALU result)
- `cpuWData`  in  DATA_W  store data
- `cpuRData`  out  DATA_W  load data
- `cpuStall`  out  1  CPU access not performed this cycle; pipeline holds MEM stage
- `dbgValid`  in  1  debug request pending
- `dbgReady`  out  1  debug request granted this cycle
- `dbgWe`  in  1  debug request is a write
- `dbgAddr`  in  ADDR_W  debug address
- `dbgWData`  in  DATA_W  debug write data
- `dbgRspValid`  out  1  `dbgRData` valid; one-cycle pulse
- `dbgRData`  out  DATA_W  registered debug read data
- `dbgHalt`  in  1  request exclusive memory ownership
- `haltAck`  out  1  exclusive ownership active
- `memAddr`  out  ADDR_W  to memory address
- `memWData`  out  DATA_W  to memory write data
- `memWe`  out  1  to memory write enable
- `memRData`  in  DATA_W  from memory; combinational read

## Operation
- FSM states: RUN and HALTED.
  - RUN → HALTED on the edge where `dbgHalt` = 1.
  - HALTED → RUN on the edge where `dbgHalt` = 0.
  - `haltAck` = (state == HALTED).
- Grant in RUN is computed combinationally from inputs and registered state:
  - `cpuReq` = 0: debug is granted if `dbgValid` = 1.
  - `cpuReq` = 1 and `dbgValid` = 0: CPU is granted.
  - `cpuReq` = 1 and `dbgValid` = 1: CPU is granted, except debug is granted when `waitCnt` == MAX_WAIT (fair mode only).
- Grant in HALTED:
  - Debug is granted whenever `dbgValid` = 1.
  - `cpuStall` = `cpuReq`.
- On a CPU grant:
  - `memAddr` = `cpuAddr`, `memWData` = `cpuWData`, `memWe` = `cpuWe`.
  - `cpuStall` = 0.
- On a debug grant:
  - `memAddr` = `dbgAddr`, `memWData` = `dbgWData`, `memWe` = `dbgWe`, `dbgReady` = 1.
  - `cpuStall` = `cpuReq`.
- `cpuRData` = `memRData` at all times. It is meaningful only when the CPU is granted.
- With no grant: `memWe` = 0, `memAddr` = `cpuAddr`, `memWData` = `cpuWData`.
- `waitCnt` (4 bits):
  - Increments when `dbgValid` = 1 and debug is not granted, saturating at MAX_WAIT.
  - Clears to 0 on a debug grant or when `dbgValid` = 0.
- A stalled CPU store never writes memory.
- Only one requester drives memory per cycle.

## Timing
- CPU path adds zero latency: address to `cpuRData` is combinational, and the store commits at the edge ending the granted cycle.
- Debug handshake:
  - A transfer occurs on the edge where `dbgValid` = 1 and `dbgReady` = 1.
  - The requester holds all `dbg*` inputs stable until that edge.
  - `dbgReady` may fall without a transfer, because CPU priority can change from cycle to cycle.
- Debug reads:
  - `dbgRData` captures `memRData` on the transfer edge.
  - `dbgRspValid` = 1 for exactly the following cycle.
- Debug writes: `dbgRData` is unchanged and `dbgRspValid` stays 0.
- Back-to-back debug transfers are allowed every cycle. `dbgRspValid` may therefore stay high across consecutive reads.
- Halt timing:
  - `dbgHalt` rising: `haltAck` rises one cycle later.
  - `dbgHalt` falling: the CPU regains priority one cycle later.
  - Debug requests are served in RUN and HALTED alike.
- Reset (`reset` = 0, sampled at edge):
  - Registered state: RUN, `waitCnt` = 0, `dbgRspValid` = 0, `dbgRData` = 0, `haltAck` = 0.
  - While reset is low: `memWe` = 0, `dbgReady` = 0, `cpuStall` = 0.
  - A debug read accepted on the edge where reset is asserted produces no response.

## Configuration
- `DMEM_ARB_FAIR_EN` defined:
  - `waitCnt` is built.
  - A debug request waits at most MAX_WAIT cycles; at most one CPU stall per MAX_WAIT+1 cycles of contention.
- Undefined:
  - No counter; strict CPU priority.
  - Debug is granted only when `cpuReq` = 0 or the FSM is HALTED, so debug can starve indefinitely in RUN.

## Structure
- Shared package `dmem_arb_pkg`:
  - FSM state enum (`ARB_RUN`, `ARB_HALTED`).
  - Grant enum (`GNT_NONE`, `GNT_CPU`, `GNT_DBG`).
  - Default widths.
- One sub-module, `dmem_arb_fair`: the wait counter and the force-debug decision. It is instantiated only under `DMEM_ARB_FAIR_EN`.
- The mux and FSM stay in the top module.

## Test plan
- Idle CPU: `dbgValid` read at address 0x10, memory word 0xDEADBEEF → `dbgReady` = 1 in the same cycle, `dbgRspValid` = 1 next cycle, `dbgRData` = 0xDEADBEEF, `cpuStall` never set.
- CPU store at 0x20 of 0x1234 with no debug request → `memWe` = 1 and `cpuStall` = 0 that cycle; a following CPU load at 0x20 returns 0x1234.
- Contention, fair mode, MAX_WAIT = 4: `cpuReq` and `dbgValid` held high → debug granted on cycle 5, `cpuStall` = 1 only on cycle 5, pattern repeats every 5 cycles.
- Contention, macro undefined → `dbgReady` stays 0 for 50 cycles and `cpuStall` stays 0; dropping `cpuReq` grants debug in the same cycle.
- Halt: assert `dbgHalt` with `cpuReq` = 1 → `haltAck` rises next cycle and `cpuStall` = 1 while halted; debug writes 0xA5 to 0x40 and reads it back as 0xA5; deassert `dbgHalt` → CPU granted one cycle later.
- Reset: pulse `reset` low during a debug read acceptance → `dbgRspValid` stays 0, state is RUN, `waitCnt` = 0, `memWe` = 0 throughout reset.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        ARB_RUN,
        ARB_HALTED
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CPU,
        GNT_DBG
    } arb_gnt_e;

    localparam int ARB_ADDR_W   = 32;
    localparam int ARB_DATA_W   = 32;
    localparam int ARB_MAX_WAIT = 4;

endpackage

// File: rtl/dmem_arb_if.sv
// CPU, debug and memory signals of the arbiter.
// The master side drives the requests and memory read data; the slave side is the arbiter.
interface dmem_arb_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
);
    logic              cpuReq;
    logic              cpuWe;
    logic [ADDR_W-1:0] cpuAddr;
    logic [DATA_W-1:0] cpuWData;
    logic [DATA_W-1:0] cpuRData;
    logic              cpuStall;
    logic              dbgValid;
    logic              dbgReady;
    logic              dbgWe;
    logic [ADDR_W-1:0] dbgAddr;
    logic [DATA_W-1:0] dbgWData;
    logic              dbgRspValid;
    logic [DATA_W-1:0] dbgRData;
    logic              dbgHalt;
    logic              haltAck;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWData;
    logic              memWe;
    logic [DATA_W-1:0] memRData;

    modport master (
        output cpuReq, cpuWe, cpuAddr, cpuWData,
        output dbgValid, dbgWe, dbgAddr, dbgWData, dbgHalt,
        output memRData,
        input  cpuRData, cpuStall, dbgReady, dbgRspValid, dbgRData, haltAck,
        input  memAddr, memWData, memWe
    );

    modport slave (
        input  cpuReq, cpuWe, cpuAddr, cpuWData,
        input  dbgValid, dbgWe, dbgAddr, dbgWData, dbgHalt,
        input  memRData,
        output cpuRData, cpuStall, dbgReady, dbgRspValid, dbgRData, haltAck,
        output memAddr, memWData, memWe
    );
endinterface

// File: rtl/dmem_arb_fair.sv
// Bounded-wait tracker for a pending debug request (built only with DMEM_ARB_FAIR_EN).
// Counts down the losses a debug request may still suffer; at zero the debug side is forced.
module dmem_arb_fair #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_dbg_valid,
    input  logic i_dbg_gnt,
    output logic o_force_dbg
);
    localparam logic [3:0] WAIT_LOAD = 4'(MAX_WAIT);

    logic [3:0] r_wait_left;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wait_left <= WAIT_LOAD;
        end else if (!i_dbg_valid || i_dbg_gnt) begin
            r_wait_left <= WAIT_LOAD;
        end else if (r_wait_left != 4'd0) begin
            r_wait_left <= r_wait_left - 4'd1;
        end
    end

    assign o_force_dbg = (r_wait_left == 4'd0);
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the MEM stage and a debug/loader port.
// Define DMEM_ARB_FAIR_EN to bound debug wait time; otherwise the CPU has strict priority.
//
// state      | meaning
// ARB_RUN    | CPU has priority, debug served on idle cycles (or when forced)
// ARB_HALTED | debug owns memory exclusively, every CPU access stalls
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ARB_ADDR_W,
    parameter int DATA_W   = ARB_DATA_W,
    parameter int MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic     clk,
    input  logic     reset,
    dmem_arb_if.slave bus
);
    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("dmem_arbiter: MAX_WAIT must be within 1..15");
    end

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    arb_gnt_e          w_gnt;
    logic              w_force_dbg;
    logic              w_dbg_gnt;
    logic              w_dbg_read;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_mem_we;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rdata;

`ifdef DMEM_ARB_FAIR_EN
    dmem_arb_fair #(
        .MAX_WAIT(MAX_WAIT)
    ) u_fair (
        .clk        (clk),
        .reset      (reset),
        .i_dbg_valid(bus.dbgValid),
        .i_dbg_gnt  (w_dbg_gnt),
        .o_force_dbg(w_force_dbg)
    );
`else
    assign w_force_dbg = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ARB_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant is held at none while reset is low so nothing touches memory.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = GNT_NONE;
        case (r_state)
            ARB_RUN: begin
                if (bus.dbgHalt) begin
                    w_state_nxt = ARB_HALTED;
                end
                if (bus.cpuReq) begin
                    w_gnt = (bus.dbgValid && w_force_dbg) ? GNT_DBG : GNT_CPU;
                end else if (bus.dbgValid) begin
                    w_gnt = GNT_DBG;
                end
            end
            ARB_HALTED: begin
                if (!bus.dbgHalt) begin
                    w_state_nxt = ARB_RUN;
                end
                if (bus.dbgValid) begin
                    w_gnt = GNT_DBG;
                end
            end
            default: w_state_nxt = ARB_RUN;
        endcase
        if (!reset) begin
            w_gnt = GNT_NONE;
        end
    end

    always_comb begin
        w_mem_addr  = bus.cpuAddr;
        w_mem_wdata = bus.cpuWData;
        w_mem_we    = 1'b0;
        case (w_gnt)
            GNT_CPU: w_mem_we = bus.cpuWe;
            GNT_DBG: begin
                w_mem_addr  = bus.dbgAddr;
                w_mem_wdata = bus.dbgWData;
                w_mem_we    = bus.dbgWe;
            end
            default: w_mem_we = 1'b0;
        endcase
    end

    assign w_dbg_gnt  = (w_gnt == GNT_DBG);
    assign w_dbg_read = w_dbg_gnt && !bus.dbgWe;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_rsp_valid <= w_dbg_read;
            if (w_dbg_read) begin
                r_rdata <= bus.memRData;
            end
        end
    end

    assign bus.memAddr     = w_mem_addr;
    assign bus.memWData    = w_mem_wdata;
    assign bus.memWe       = w_mem_we;
    assign bus.cpuRData    = bus.memRData;
    assign bus.cpuStall    = reset && bus.cpuReq && (w_gnt != GNT_CPU);
    assign bus.dbgReady    = w_dbg_gnt;
    assign bus.dbgRspValid = r_rsp_valid;
    assign bus.dbgRData    = r_rdata;
    assign bus.haltAck     = (r_state == ARB_HALTED);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model of the arbitration rules.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
`ifdef DMEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;

    logic [31:0] mem     [0:63];
    logic [31:0] exp_mem [0:63];

    dmem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Word-addressed memory with combinational read; reset reloads a known pattern.
    assign bus.memRData = mem[bus.memAddr[7:2]];
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (bus.memWe) begin
            mem[bus.memAddr[7:2]] <= bus.memWData;
        end
    end

    function automatic logic [31:0] raddr();
        return {24'h0, 6'($urandom_range(0, 63)), 2'b00};
    endfunction

    task automatic idle_inputs();
        bus.cpuReq = 1'b0; bus.cpuWe = 1'b0; bus.cpuAddr = '0; bus.cpuWData = '0;
        bus.dbgValid = 1'b0; bus.dbgWe = 1'b0; bus.dbgAddr = '0; bus.dbgWData = '0;
        bus.dbgHalt = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        for (int i = 0; i < 64; i++) exp_mem[i] = 32'h1000_0000 + 32'(i);
    endtask

    task automatic test_reset();
        do_reset();
        // build up some waiting history, then a debug read accepted as reset falls
        bus.cpuReq = 1'b1; bus.dbgValid = 1'b1; bus.dbgAddr = 32'h10;
        next_cycle();
        next_cycle();
        bus.cpuReq = 1'b0;
        @(negedge clk);
        n_total++; if (bus.dbgReady !== 1'b1) $display("FAIL rst_pre_ready got %b want 1", bus.dbgReady); else n_pass++;
        reset = 1'b0; bus.cpuReq = 1'b1; bus.cpuWe = 1'b1; bus.dbgHalt = 1'b1;
        #1;
        n_total++; if (bus.dbgReady !== 1'b0) $display("FAIL rst_ready got %b want 0", bus.dbgReady); else n_pass++;
        n_total++; if (bus.memWe !== 1'b0) $display("FAIL rst_memwe got %b want 0", bus.memWe); else n_pass++;
        n_total++; if (bus.cpuStall !== 1'b0) $display("FAIL rst_stall got %b want 0", bus.cpuStall); else n_pass++;
        next_cycle();
        n_total++; if (bus.dbgRspValid !== 1'b0) $display("FAIL rst_rsp got %b want 0", bus.dbgRspValid); else n_pass++;
        n_total++; if (bus.dbgRData !== 32'h0) $display("FAIL rst_rdata got %h want 0", bus.dbgRData); else n_pass++;
        n_total++; if (bus.haltAck !== 1'b0) $display("FAIL rst_haltack got %b want 0", bus.haltAck); else n_pass++;
        n_total++; if (bus.memWe !== 1'b0) $display("FAIL rst_memwe2 got %b want 0", bus.memWe); else n_pass++;
        next_cycle();
        reset = 1'b1; bus.dbgHalt = 1'b0; bus.cpuWe = 1'b0;
        for (int i = 0; i < 64; i++) exp_mem[i] = 32'h1000_0000 + 32'(i);
        // contention straight out of reset: the wait history must have been cleared
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_total++;
            if (bus.dbgReady !== (FAIR && k == 4))
                $display("FAIL rst_wait_clear cyc %0d got %b want %b", k, bus.dbgReady, FAIR && k == 4);
            else n_pass++;
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        n_total++; if (bus.haltAck !== 1'b0) $display("FAIL rst_state_run got %b want 0", bus.haltAck); else n_pass++;
        next_cycle();
    endtask

    task automatic test_idle_dbg_read();
        idle_inputs();
        bus.dbgValid = 1'b1; bus.dbgWe = 1'b1; bus.dbgAddr = 32'h10; bus.dbgWData = 32'hDEAD_BEEF;
        @(negedge clk);
        n_total++; if (bus.dbgReady !== 1'b1) $display("FAIL idle_wr_ready got %b want 1", bus.dbgReady); else n_pass++;
        n_total++; if (bus.memWe !== 1'b1) $display("FAIL idle_wr_memwe got %b want 1", bus.memWe); else n_pass++;
        next_cycle();
        bus.dbgWe = 1'b0;
        @(negedge clk);
        n_total++; if (bus.dbgRspValid !== 1'b0) $display("FAIL idle_wr_norsp got %b want 0", bus.dbgRspValid); else n_pass++;
        n_total++; if (bus.dbgReady !== 1'b1) $display("FAIL idle_rd_ready got %b want 1", bus.dbgReady); else n_pass++;
        n_total++; if (bus.cpuStall !== 1'b0) $display("FAIL idle_rd_stall got %b want 0", bus.cpuStall); else n_pass++;
        next_cycle();
        bus.dbgValid = 1'b0;
        @(negedge clk);
        n_total++; if (bus.dbgRspValid !== 1'b1) $display("FAIL idle_rd_rsp got %b want 1", bus.dbgRspValid); else n_pass++;
        n_total++; if (bus.dbgRData !== 32'hDEAD_BEEF) $display("FAIL idle_rd_data got %h want deadbeef", bus.dbgRData); else n_pass++;
        next_cycle();
        bus.dbgValid = 1'b1; bus.dbgWe = 1'b1; bus.dbgAddr = 32'h14; bus.dbgWData = 32'h5555_AAAA;
        @(negedge clk);
        n_total++; if (bus.dbgRspValid !== 1'b0) $display("FAIL idle_rsp_pulse got %b want 0", bus.dbgRspValid); else n_pass++;
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_total++; if (bus.dbgRData !== 32'hDEAD_BEEF) $display("FAIL idle_wr_keep got %h want deadbeef", bus.dbgRData); else n_pass++;
        n_total++; if (bus.dbgRspValid !== 1'b0) $display("FAIL idle_wr_rsp got %b want 0", bus.dbgRspValid); else n_pass++;
        next_cycle();
    endtask

    task automatic test_cpu_store_load();
        idle_inputs();
        bus.cpuReq = 1'b1; bus.cpuWe = 1'b1; bus.cpuAddr = 32'h20; bus.cpuWData = 32'h1234;
        @(negedge clk);
        n_total++; if (bus.memWe !== 1'b1) $display("FAIL cpu_st_memwe got %b want 1", bus.memWe); else n_pass++;
        n_total++; if (bus.cpuStall !== 1'b0) $display("FAIL cpu_st_stall got %b want 0", bus.cpuStall); else n_pass++;
        n_total++; if (bus.memAddr !== 32'h20) $display("FAIL cpu_st_addr got %h want 20", bus.memAddr); else n_pass++;
        n_total++; if (bus.memWData !== 32'h1234) $display("FAIL cpu_st_wdata got %h want 1234", bus.memWData); else n_pass++;
        next_cycle();
        bus.cpuWe = 1'b0; bus.cpuWData = 32'hFFFF_0000;
        @(negedge clk);
        n_total++; if (bus.cpuRData !== 32'h1234) $display("FAIL cpu_ld_data got %h want 1234", bus.cpuRData); else n_pass++;
        n_total++; if (bus.memWe !== 1'b0) $display("FAIL cpu_ld_memwe got %b want 0", bus.memWe); else n_pass++;
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_contention();
        idle_inputs();
        next_cycle();
        bus.cpuReq = 1'b1; bus.dbgValid = 1'b1; bus.dbgAddr = 32'h8;
`ifdef DMEM_ARB_FAIR_EN
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            n_total++;
            if (bus.dbgReady !== (k % 5 == 4)) $display("FAIL fair_ready cyc %0d got %b want %b", k + 1, bus.dbgReady, k % 5 == 4);
            else n_pass++;
            n_total++;
            if (bus.cpuStall !== (k % 5 == 4)) $display("FAIL fair_stall cyc %0d got %b want %b", k + 1, bus.cpuStall, k % 5 == 4);
            else n_pass++;
            next_cycle();
        end
`else
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            n_total++;
            if (bus.dbgReady !== 1'b0 || bus.cpuStall !== 1'b0)
                $display("FAIL strict_starve cyc %0d ready %b stall %b want 0 0", k, bus.dbgReady, bus.cpuStall);
            else n_pass++;
            next_cycle();
        end
        bus.cpuReq = 1'b0;
        @(negedge clk);
        n_total++; if (bus.dbgReady !== 1'b1) $display("FAIL strict_drop_cpu got %b want 1", bus.dbgReady); else n_pass++;
        next_cycle();
`endif
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_halt();
        idle_inputs();
        bus.cpuReq = 1'b1; bus.cpuAddr = 32'h40; bus.dbgHalt = 1'b1;
        @(negedge clk);
        n_total++; if (bus.haltAck !== 1'b0) $display("FAIL halt_ack_early got %b want 0", bus.haltAck); else n_pass++;
        n_total++; if (bus.cpuStall !== 1'b0) $display("FAIL halt_stall_early got %b want 0", bus.cpuStall); else n_pass++;
        next_cycle();
        bus.cpuWe = 1'b1; bus.cpuWData = 32'hFFFF_FFFF;
        bus.dbgValid = 1'b1; bus.dbgWe = 1'b1; bus.dbgAddr = 32'h40; bus.dbgWData = 32'hA5;
        @(negedge clk);
        n_total++; if (bus.haltAck !== 1'b1) $display("FAIL halt_ack got %b want 1", bus.haltAck); else n_pass++;
        n_total++; if (bus.cpuStall !== 1'b1) $display("FAIL halt_stall got %b want 1", bus.cpuStall); else n_pass++;
        n_total++; if (bus.memWData !== 32'hA5) $display("FAIL halt_wr_data got %h want a5", bus.memWData); else n_pass++;
        next_cycle();
        bus.dbgWe = 1'b0;
        @(negedge clk);
        n_total++; if (bus.dbgReady !== 1'b1) $display("FAIL halt_rd_ready got %b want 1", bus.dbgReady); else n_pass++;
        next_cycle();
        bus.dbgValid = 1'b0;
        @(negedge clk);
        n_total++; if (bus.dbgRData !== 32'hA5) $display("FAIL halt_rd_data got %h want a5", bus.dbgRData); else n_pass++;
        n_total++; if (bus.memWe !== 1'b0) $display("FAIL halt_no_cpu_store got %b want 0", bus.memWe); else n_pass++;
        next_cycle();
        bus.dbgHalt = 1'b0;
        @(negedge clk);
        n_total++; if (bus.cpuStall !== 1'b1) $display("FAIL halt_release_stall got %b want 1", bus.cpuStall); else n_pass++;
        next_cycle();
        @(negedge clk);
        n_total++; if (bus.haltAck !== 1'b0) $display("FAIL halt_ack_drop got %b want 0", bus.haltAck); else n_pass++;
        n_total++; if (bus.cpuStall !== 1'b0 || bus.memWe !== 1'b1)
            $display("FAIL halt_cpu_back stall %b memwe %b want 0 1", bus.cpuStall, bus.memWe);
        else n_pass++;
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_random();
        logic [31:0] d_addr, d_wd, exp_rdata;
        logic        d_v, d_we, pend, halted, dbg_win, cpu_win, exp_rsp, exp_we;
        int          lost;
        do_reset();
        d_addr = '0; d_wd = '0; d_v = 1'b0; d_we = 1'b0; pend = 1'b0;
        halted = 1'b0; lost = 0; exp_rsp = 1'b0; exp_rdata = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pend) begin
                d_v = ($urandom_range(0, 2) != 0); d_we = ($urandom_range(0, 1) == 1);
                d_addr = raddr(); d_wd = $urandom;
            end
            bus.cpuReq = ($urandom_range(0, 3) != 0); bus.cpuWe = ($urandom_range(0, 1) == 1);
            bus.cpuAddr = raddr(); bus.cpuWData = $urandom;
            if ($urandom_range(0, 19) == 0) bus.dbgHalt = ~bus.dbgHalt;
            bus.dbgValid = d_v; bus.dbgWe = d_we; bus.dbgAddr = d_addr; bus.dbgWData = d_wd;
            // who owns memory this cycle, straight from the arbitration rules
            dbg_win = d_v && (halted || !bus.cpuReq || (FAIR && lost >= MW));
            cpu_win = bus.cpuReq && !halted && !dbg_win;
            exp_we  = cpu_win ? bus.cpuWe : (dbg_win ? d_we : 1'b0);
            @(negedge clk);
            n_total++; if (bus.dbgReady !== dbg_win) $display("FAIL rnd_ready cyc %0d got %b want %b", c, bus.dbgReady, dbg_win); else n_pass++;
            n_total++; if (bus.cpuStall !== (bus.cpuReq && !cpu_win)) $display("FAIL rnd_stall cyc %0d got %b want %b", c, bus.cpuStall, bus.cpuReq && !cpu_win); else n_pass++;
            n_total++; if (bus.memWe !== exp_we) $display("FAIL rnd_memwe cyc %0d got %b want %b", c, bus.memWe, exp_we); else n_pass++;
            n_total++; if (bus.haltAck !== halted) $display("FAIL rnd_haltack cyc %0d got %b want %b", c, bus.haltAck, halted); else n_pass++;
            n_total++; if (bus.dbgRspValid !== exp_rsp) $display("FAIL rnd_rsp cyc %0d got %b want %b", c, bus.dbgRspValid, exp_rsp); else n_pass++;
            n_total++; if (bus.dbgRData !== exp_rdata) $display("FAIL rnd_rdata cyc %0d got %h want %h", c, bus.dbgRData, exp_rdata); else n_pass++;
            if (cpu_win && !bus.cpuWe) begin
                n_total++;
                if (bus.cpuRData !== exp_mem[bus.cpuAddr[7:2]]) $display("FAIL rnd_cpu_load cyc %0d got %h want %h", c, bus.cpuRData, exp_mem[bus.cpuAddr[7:2]]);
                else n_pass++;
            end
            if (dbg_win) begin
                n_total++;
                if (bus.memAddr !== d_addr) $display("FAIL rnd_dbg_addr cyc %0d got %h want %h", c, bus.memAddr, d_addr); else n_pass++;
            end
            next_cycle();
            exp_rsp = dbg_win && !d_we;
            if (exp_rsp) exp_rdata = exp_mem[d_addr[7:2]];
            if (cpu_win && bus.cpuWe) exp_mem[bus.cpuAddr[7:2]] = bus.cpuWData;
            if (dbg_win && d_we) exp_mem[d_addr[7:2]] = d_wd;
            if (d_v && !dbg_win) lost = (lost < MW) ? lost + 1 : MW;
            else lost = 0;
            halted = bus.dbgHalt;
            pend = d_v && !dbg_win;
        end
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_idle_dbg_read();
        test_cpu_store_load();
        test_contention();
        test_halt();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
